// File: rtl/n101_pwm8_seq.sv
// Duty-cycle sequencer that drives n101_pwm8_core cmp write ports for ramp, triangle and sawtooth fades.
// Optional gamma output mapping is enabled by defining N101_PWM_SEQ_GAMMA_EN.
module n101_pwm8_seq #(
   parameter int HOLD_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        cfg_mode,
   input  logic [7:0]        cfg_min,
   input  logic [7:0]        cfg_max,
   input  logic [7:0]        cfg_step,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic [3:0]        cfg_chmask,
`ifdef N101_PWM_SEQ_GAMMA_EN
   input  logic              cfg_gamma,
`endif
   input  logic              pwm_ip0,
   output logic [3:0]        cmp_wr_valid,
   output logic [7:0]        cmp_wr_bits,
   output logic              busy,
   output logic [7:0]        duty,
   output logic              dir_down,
   output logic              done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_UPD  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [7:0]        min_q, min_d;
   logic [7:0]        max_q, max_d;
   logic [7:0]        step_q, step_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        mask_q, mask_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [7:0]        duty_q, duty_d;
   logic              dir_q, dir_d;
   logic              ip0_q;
   logic              tick;
   logic              wr_en;
   logic [8:0]        up_sum;
   logic signed [8:0] dn_diff;

   assign tick    = pwm_ip0 & ~ip0_q;
   assign up_sum  = {1'b0, duty_q} + {1'b0, step_q};
   assign dn_diff = $signed({1'b0, duty_q}) - $signed({1'b0, step_q});

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      min_d   = min_q;
      max_d   = max_q;
      step_d  = step_q;
      hold_d  = hold_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      wr_en   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               mode_d  = cfg_mode;
               min_d   = cfg_min;
               max_d   = cfg_max;
               step_d  = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
               hold_d  = (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;
               mask_d  = cfg_chmask;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            wr_en  = 1'b1;
            cnt_d  = hold_q;
            dir_d  = (mode_q == 2'd1);
            duty_d = (mode_q == 2'd1) ? max_q : min_q;
            state_d = (min_q >= max_q) ? S_FIN : S_WAIT;
         end
         S_WAIT: begin
            if (tick) begin
               cnt_d = cnt_q - HOLD_W'(1);
               if (cnt_q == HOLD_W'(1)) state_d = S_UPD;
            end
         end
         S_UPD: begin
            wr_en   = 1'b1;
            cnt_d   = hold_q;
            state_d = S_WAIT;
            if (!dir_q) begin
               if (up_sum >= {1'b0, max_q}) begin
                  // Sawtooth wraps straight to min so max itself is never emitted
                  if (mode_q == 2'd3) begin
                     duty_d = min_q;
                  end else if (mode_q == 2'd2) begin
                     duty_d = max_q;
                     dir_d  = 1'b1;
                  end else begin
                     duty_d  = max_q;
                     state_d = S_FIN;
                  end
               end else begin
                  duty_d = up_sum[7:0];
               end
            end else begin
               if (dn_diff <= $signed({1'b0, min_q})) begin
                  duty_d = min_q;
                  if (mode_q == 2'd2) dir_d = 1'b0;
                  else                state_d = S_FIN;
               end else begin
                  duty_d = dn_diff[7:0];
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort outranks any same-cycle update: nothing written, state frozen
      if (stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = cnt_q;
         duty_d  = duty_q;
         dir_d   = dir_q;
         wr_en   = 1'b0;
      end
   end

`ifdef N101_PWM_SEQ_GAMMA_EN
   logic        gamma_q, gamma_d;
   logic [15:0] sq;
   assign gamma_d = (state_q == S_IDLE && start && !stop) ? cfg_gamma : gamma_q;
   assign sq      = {8'd0, duty_d} * {8'd0, duty_d};
   assign cmp_wr_bits = gamma_q ? sq[15:8] : duty_d;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) gamma_q <= 1'b0;
      else       gamma_q <= gamma_d;
   end
`else
   assign cmp_wr_bits = duty_d;
`endif

   assign cmp_wr_valid = wr_en ? mask_q : 4'd0;
   assign busy         = (state_q != S_IDLE);
   assign duty         = duty_q;
   assign dir_down     = dir_q;
   assign done         = (state_q == S_FIN) && !stop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         min_q   <= 8'd0;
         max_q   <= 8'd0;
         step_q  <= 8'd0;
         hold_q  <= '0;
         mask_q  <= 4'd0;
         cnt_q   <= '0;
         duty_q  <= 8'd0;
         dir_q   <= 1'b0;
         ip0_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         min_q   <= min_d;
         max_q   <= max_d;
         step_q  <= step_d;
         hold_q  <= hold_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         ip0_q   <= pwm_ip0;
      end
   end

endmodule

// File: tb/tb_n101_pwm8_seq.sv
// Directed bench for n101_pwm8_seq: write sequences, done pulses, stop/start/reset corner cases.
module tb_n101_pwm8_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic [1:0] cfg_mode = 2'd0;
   logic [7:0] cfg_min = 8'd0, cfg_max = 8'd0, cfg_step = 8'd0;
   logic [7:0] cfg_hold = 8'd0;
   logic [3:0] cfg_chmask = 4'd0;
`ifdef N101_PWM_SEQ_GAMMA_EN
   logic       cfg_gamma = 1'b0;
`endif
   logic       pwm_ip0 = 1'b0;
   logic [3:0] cmp_wr_valid;
   logic [7:0] cmp_wr_bits;
   logic       busy, dir_down, done;
   logic [7:0] duty;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int b2b = 0;
   logic prev_wr = 1'b0;
   logic [11:0] wq[$];
   logic [11:0] exp_q[$];

   n101_pwm8_seq #(.HOLD_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .cfg_mode(cfg_mode), .cfg_min(cfg_min), .cfg_max(cfg_max),
      .cfg_step(cfg_step), .cfg_hold(cfg_hold), .cfg_chmask(cfg_chmask),
`ifdef N101_PWM_SEQ_GAMMA_EN
      .cfg_gamma(cfg_gamma),
`endif
      .pwm_ip0(pwm_ip0), .cmp_wr_valid(cmp_wr_valid), .cmp_wr_bits(cmp_wr_bits),
      .busy(busy), .duty(duty), .dir_down(dir_down), .done(done)
   );

   always #5 clock = ~clock;

   // Write/done monitor sampled mid-cycle
   always @(negedge clock) begin
      if (!reset) begin
         if (cmp_wr_valid != 4'd0) begin
            wq.push_back({cmp_wr_valid, cmp_wr_bits});
            if (prev_wr) b2b++;
         end
         if (done) done_cnt++;
         prev_wr = (cmp_wr_valid != 4'd0);
      end else begin
         prev_wr = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic ew(input logic [3:0] m, input logic [7:0] v);
      exp_q.push_back({m, v});
   endtask

   task automatic cmp_writes(input string tag);
      chk({tag, "_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), {20'd0, wq[i]}, {20'd0, exp_q[i]});
      wq.delete();
      exp_q.delete();
   endtask

   task automatic do_start(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] st, input logic [7:0] hd, input logic [3:0] mk);
      cfg_mode = m; cfg_min = lo; cfg_max = hi; cfg_step = st; cfg_hold = hd; cfg_chmask = mk;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic ticks(input int n, input int period, input int width);
      for (int i = 0; i < n; i++) begin
         pwm_ip0 = 1'b1;
         cyc(width);
         pwm_ip0 = 1'b0;
         cyc(period - width);
      end
   endtask

   task automatic do_stop();
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
   endtask

   initial begin
      cyc(3);
      reset = 1'b0;
      cyc(1);
      chk("rst_busy", busy, 0);
      chk("rst_duty", duty, 0);
      chk("rst_dir", dir_down, 0);
      chk("rst_valid", cmp_wr_valid, 0);
      chk("rst_bits", cmp_wr_bits, 0);
      chk("rst_done", done, 0);

      // Mode 0 ramp up, hold 2, channels 0 and 2
      do_start(2'd0, 8'd0, 8'd100, 8'd30, 8'd2, 4'b0101);
      chk("m0_lat_valid", cmp_wr_valid, 4'b0101);
      chk("m0_lat_bits", cmp_wr_bits, 0);
      cyc(1);
      ticks(8, 10, 1);
      ew(4'b0101, 8'd0); ew(4'b0101, 8'd30); ew(4'b0101, 8'd60);
      ew(4'b0101, 8'd90); ew(4'b0101, 8'd100);
      cmp_writes("m0");
      chk("m0_done", done_cnt, 1);
      chk("m0_busy", busy, 0);
      chk("m0_duty", duty, 100);

      // Mode 2 triangle
      do_start(2'd2, 8'd10, 8'd20, 8'd4, 8'd1, 4'b1111);
      cyc(1);
      ticks(3, 6, 1);
      chk("m2_dir_top", dir_down, 1);
      chk("m2_duty_top", duty, 20);
      ticks(3, 6, 1);
      chk("m2_dir_bot", dir_down, 0);
      ticks(1, 6, 1);
      ew(4'hF, 8'd10); ew(4'hF, 8'd14); ew(4'hF, 8'd18); ew(4'hF, 8'd20);
      ew(4'hF, 8'd16); ew(4'hF, 8'd12); ew(4'hF, 8'd10); ew(4'hF, 8'd14);
      cmp_writes("m2");
      chk("m2_busy", busy, 1);
      do_stop();
      chk("m2_stop_busy", busy, 0);
      chk("m2_stop_duty", duty, 14);
      chk("m2_no_done", done_cnt, 1);

      // Mode 3 sawtooth, wrap without writing max
      do_start(2'd3, 8'd0, 8'd250, 8'd100, 8'd1, 4'b0010);
      cyc(1);
      ticks(4, 6, 1);
      ew(4'b0010, 8'd0); ew(4'b0010, 8'd100); ew(4'b0010, 8'd200);
      ew(4'b0010, 8'd0); ew(4'b0010, 8'd100);
      cmp_writes("m3");
      do_stop();

      // Mode 1 ramp down
      do_start(2'd1, 8'd5, 8'd20, 8'd10, 8'd1, 4'b0001);
      chk("m1_dir_load", busy, 1);
      cyc(1);
      chk("m1_dir", dir_down, 1);
      ticks(2, 6, 1);
      ew(4'b0001, 8'd20); ew(4'b0001, 8'd10); ew(4'b0001, 8'd5);
      cmp_writes("m1");
      chk("m1_done", done_cnt, 2);
      chk("m1_busy", busy, 0);

      // Degenerate min == max
      do_start(2'd0, 8'd50, 8'd50, 8'd3, 8'd4, 4'b1000);
      cyc(3);
      ew(4'b1000, 8'd50);
      cmp_writes("degen");
      chk("degen_done", done_cnt, 3);
      chk("degen_busy", busy, 0);

      // step 0 and hold 0 act as 1
      do_start(2'd0, 8'd0, 8'd3, 8'd0, 8'd0, 4'b0001);
      cyc(1);
      ticks(3, 5, 1);
      ew(4'b0001, 8'd0); ew(4'b0001, 8'd1); ew(4'b0001, 8'd2); ew(4'b0001, 8'd3);
      cmp_writes("zero");
      chk("zero_done", done_cnt, 4);

      // ip0 held high for 5 cycles is one tick
      do_start(2'd0, 8'd0, 8'd10, 8'd5, 8'd1, 4'b0001);
      cyc(1);
      ticks(1, 10, 5);
      ew(4'b0001, 8'd0); ew(4'b0001, 8'd5);
      cmp_writes("wide");
      chk("wide_busy", busy, 1);
      ticks(1, 5, 1);
      ew(4'b0001, 8'd10);
      cmp_writes("wide_end");
      chk("wide_done", done_cnt, 5);

      // stop coincident with a tick in WAIT
      do_start(2'd2, 8'd10, 8'd20, 8'd4, 8'd1, 4'b0011);
      cyc(2);
      pwm_ip0 = 1'b1;
      stop = 1'b1;
      cyc(1);
      pwm_ip0 = 1'b0;
      stop = 1'b0;
      chk("stoptick_busy", busy, 0);
      chk("stoptick_duty", duty, 10);
      cyc(2);
      ew(4'b0011, 8'd10);
      cmp_writes("stoptick");

      // start and stop together in IDLE
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", busy, 0);
      cyc(1);
      chk("ss_nowr", wq.size(), 0);

      // start while busy is ignored, then reset mid-WAIT
      do_start(2'd0, 8'd0, 8'd100, 8'd30, 8'd2, 4'b0101);
      cyc(1);
      do_start(2'd1, 8'd0, 8'd200, 8'd7, 8'd1, 4'b1111);
      cyc(1);
      ticks(2, 6, 1);
      ew(4'b0101, 8'd0); ew(4'b0101, 8'd30);
      cmp_writes("busy_start");
      chk("busy_dir", dir_down, 0);
      reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_duty", duty, 0);
      chk("arst_valid", cmp_wr_valid, 0);
      chk("arst_bits", cmp_wr_bits, 0);
      cyc(2);
      reset = 1'b0;
      cyc(1);
      chk("arst_idle", busy, 0);

`ifdef N101_PWM_SEQ_GAMMA_EN
      cfg_gamma = 1'b1;
      do_start(2'd0, 8'd0, 8'd255, 8'd128, 8'd1, 4'b0001);
      cfg_gamma = 1'b0;
      cyc(1);
      chk("g_duty0", duty, 0);
      ticks(1, 6, 1);
      chk("g_duty1", duty, 128);
      ticks(1, 6, 1);
      chk("g_duty2", duty, 255);
      ew(4'b0001, 8'd0); ew(4'b0001, 8'd64); ew(4'b0001, 8'd254);
      cmp_writes("gamma");
`endif

      chk("no_b2b", b2b, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/n101_pwm8_seq.md
Name: n101_pwm8_seq

Overview:
- Duty-cycle sequencer that sits beside n101_pwm8_core and drives its cmp_N register write ports to generate hardware fades (ramps and triangle/sawtooth breathing) without CPU involvement.
- Period boundaries are taken from the core's channel-0 interrupt-pending output.
- Configuration is latched at start. Status and a done pulse go to the peripheral register block.

Parameters:
- HOLD_W, 8, width of the hold counter (PWM periods between duty updates).

Ports:
- clock  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begin sequence (ignored while busy)
- stop  input  1  one-cycle pulse; abort sequence
- cfg_mode  input  2  0 = ramp up once; 1 = ramp down once; 2 = triangle continuous; 3 = sawtooth continuous
- cfg_min  input  8  lower duty bound
- cfg_max  input  8  upper duty bound
- cfg_step  input  8  duty increment per update (0 is treated as 1)
- cfg_hold  input  HOLD_W  PWM periods per update (0 is treated as 1)
- cfg_chmask  input  4  channels to write
- pwm_ip0  input  1  io_ip_0 from the PWM core
- cmp_wr_valid  output  4  per-channel cmp write strobe (= chmask when writing)
- cmp_wr_bits  output  8  value written to cmp
- busy  output  1  sequence active
- duty  output  8  current duty value (pre-gamma)
- dir_down  output  1  current direction
- done  output  1  one-cycle pulse when a one-shot sequence completes

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, latched config 0, ip0 delay register 0.
- Period tick: `tick = pwm_ip0 & ~ip0_q`, where ip0_q is pwm_ip0 registered every cycle regardless of state.
- States: IDLE, LOAD, WAIT, UPD, FIN.
- IDLE:
  - busy = 0.
  - On start: latch mode, min, max, step (0 becomes 1), hold (0 becomes 1), chmask. Go to LOAD.
- LOAD (1 cycle):
  - Modes 0, 2, 3: duty = min, dir_down = 0. Mode 1: duty = max, dir_down = 1.
  - cmp_wr_valid = chmask; cmp_wr_bits = start value.
  - Hold counter = hold. Go to WAIT, or to FIN if min >= max (degenerate case: one write of min, or max for mode 1).
  - Latency: start pulse to write strobe is exactly 1 cycle.
- WAIT: on each tick, decrement the hold counter. When the counter is 1 and a tick occurs, go to UPD.
- UPD (1 cycle): compute next duty with 9-bit arithmetic (no 8-bit wrap), then write it (cmp_wr_valid = chmask) and reload the hold counter.
  - Up, duty + step >= max: duty = max.
    - Mode 0: write, then FIN.
    - Mode 2: write, dir_down = 1, then WAIT.
    - Mode 3: next duty = min (the value max is never written at the wrap), then WAIT.
  - Up, otherwise: duty += step, then WAIT.
  - Down, duty - step <= min (signed 9-bit): duty = min.
    - Mode 1: write, then FIN.
    - Mode 2: write, dir_down = 0, then WAIT.
  - Down, otherwise: duty -= step, then WAIT.
- FIN (1 cycle): done = 1, busy = 0 next cycle, go to IDLE. duty holds its last value.
- busy = 1 in LOAD, WAIT, UPD and FIN.
- stop (any non-IDLE state): go to IDLE next cycle. No write, no done, duty unchanged. stop has priority over a same-cycle tick or update.
- start while busy: ignored. start and stop in the same cycle in IDLE: stop wins and start is ignored.
- cfg_* inputs changing while busy have no effect until the next start.
- cmp_wr_valid is a one-cycle strobe, never asserted in two consecutive cycles. cmp_wr_valid is 0 in IDLE, WAIT and FIN.
- Asynchronous reset mid-sequence returns to IDLE with outputs 0. The PWM core's cmp registers are not restored.

Optional Feature:
- Macro: N101_PWM_SEQ_GAMMA_EN.
- Defined: adds input `cfg_gamma` (1 bit), latched at start. When the latched value is 1, cmp_wr_bits = (duty*duty) >> 8, a 16-bit product taking bits [15:8] (255 gives 254, 128 gives 64, 16 gives 1). duty and the sequencing are unchanged.
- Not defined: no cfg_gamma port; cmp_wr_bits = duty always.

Test Plan:
- Mode 0, min = 0, max = 100, step = 30, hold = 2, mask = 4'b0101; tick every 10 cycles -> writes 0, 30, 60, 90, 100 on channels 0 and 2 only, one update per 2 ticks; done pulses once; busy then returns to 0.
- Mode 2, min = 10, max = 20, step = 4, hold = 1 -> write sequence 10, 14, 18, 20, 16, 12, 10, 14…; dir_down toggles at 20 and at 10; done never asserts.
- Mode 3, min = 0, max = 250, step = 100, hold = 1 -> writes 0, 100, 200, 0, 100…; no write of 250; no 8-bit overflow.
- Edge cases: min = max = 50 -> single write of 50, then done. step = 0 and hold = 0 -> behave as 1. pwm_ip0 held high for 5 cycles -> exactly one tick.
- stop in WAIT on the same cycle as a tick -> no write; IDLE next cycle; duty unchanged. start while busy -> ignored. Reset asserted mid-WAIT -> all outputs 0 immediately.
- With N101_PWM_SEQ_GAMMA_EN and cfg_gamma = 1, mode 0, min = 0, max = 255, step = 128 -> cmp_wr_bits 0, 64, 254 while duty reads 0, 128, 255.
